// File: rtl/db_read_addr_gen.sv
// db_read_addr_gen: affine read-address generator for the double-buffer memory core.
// Walks up to NUM_DIMS nested loops from a base address, emits iter_cnt addresses over a
// valid/ready handshake, then pulses done for one cycle.
module db_read_addr_gen #(
  parameter int ADDR_W   = 16,
  parameter int RANGE_W  = 32,
  parameter int NUM_DIMS = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            starting_addr,
  input  logic [3:0]                   dimensionality,
  input  logic [NUM_DIMS*ADDR_W-1:0]   stride,
  input  logic [NUM_DIMS*RANGE_W-1:0]  range,
  input  logic [RANGE_W-1:0]           iter_cnt,
  output logic [ADDR_W-1:0]            addr_out,
  output logic                         addr_valid,
  input  logic                         addr_ready,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_DIMS = 4'(NUM_DIMS);

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0]  base_q;
  logic [3:0]         dims_q;
  logic [ADDR_W-1:0]  stride_q [NUM_DIMS];
  logic [RANGE_W-1:0] range_q  [NUM_DIMS];
  logic [RANGE_W-1:0] iter_q;

  logic [RANGE_W-1:0] cnt_q    [NUM_DIMS];
  logic [RANGE_W-1:0] cnt_d    [NUM_DIMS];
  logic [ADDR_W-1:0]  off_q    [NUM_DIMS];
  logic [ADDR_W-1:0]  off_d    [NUM_DIMS];
  logic [NUM_DIMS:0]  carry;
  logic [RANGE_W-1:0] emit_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_next;
  logic [3:0]         dims_in;

  logic accept;
  logic xfer;
  logic last_xfer;

  assign accept    = (state_q == IDLE) && start;
  assign xfer      = (state_q == RUN) && addr_ready;
  assign last_xfer = xfer && (emit_q == (iter_q - 1'b1));
  assign addr_out  = addr_q;

  // Normalise the requested dimensionality: zero means one loop, anything above NUM_DIMS is capped.
  always_comb begin
    dims_in = dimensionality;
    if (dimensionality == 4'd0) begin
      dims_in = 4'd1;
    end else if (dimensionality > MAX_DIMS) begin
      dims_in = MAX_DIMS;
    end
  end

  // Advance the loop nest by one step: each dimension keeps a running offset (cnt*stride) so the
  // next address is a sum of registers rather than a set of multiplies.
  always_comb begin
    carry[0] = 1'b1;
    for (int i = 0; i < NUM_DIMS; i++) begin
      cnt_d[i]     = cnt_q[i];
      off_d[i]     = off_q[i];
      carry[i + 1] = 1'b0;
      if ((4'(i) < dims_q) && carry[i]) begin
        if (cnt_q[i] == (range_q[i] - 1'b1)) begin
          cnt_d[i]     = '0;
          off_d[i]     = '0;
          carry[i + 1] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
          off_d[i] = off_q[i] + stride_q[i];
        end
      end
    end
    addr_next = base_q;
    for (int i = 0; i < NUM_DIMS; i++) begin
      addr_next = addr_next + off_d[i];
    end
  end

  // State register; flush is an abort with exactly the same effect as reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (iter_cnt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
        if (last_xfer) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Configuration capture on accept, then counter/offset/address update on every transfer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      base_q <= '0;
      dims_q <= '0;
      iter_q <= '0;
      emit_q <= '0;
      addr_q <= '0;
      for (int i = 0; i < NUM_DIMS; i++) begin
        stride_q[i] <= '0;
        range_q[i]  <= '0;
        cnt_q[i]    <= '0;
        off_q[i]    <= '0;
      end
    end else if (accept) begin
      base_q <= starting_addr;
      dims_q <= dims_in;
      iter_q <= iter_cnt;
      emit_q <= '0;
      addr_q <= (iter_cnt != '0) ? starting_addr : '0;
      for (int i = 0; i < NUM_DIMS; i++) begin
        stride_q[i] <= stride[i*ADDR_W +: ADDR_W];
        range_q[i]  <= (range[i*RANGE_W +: RANGE_W] == '0) ? RANGE_W'(1)
                                                            : range[i*RANGE_W +: RANGE_W];
        cnt_q[i]    <= '0;
        off_q[i]    <= '0;
      end
    end else if (xfer) begin
      if (last_xfer) begin
        emit_q <= '0;
        addr_q <= '0;
        for (int i = 0; i < NUM_DIMS; i++) begin
          cnt_q[i] <= '0;
          off_q[i] <= '0;
        end
      end else begin
        emit_q <= emit_q + 1'b1;
        addr_q <= addr_next;
        for (int i = 0; i < NUM_DIMS; i++) begin
          cnt_q[i] <= cnt_d[i];
          off_q[i] <= off_d[i];
        end
      end
    end
  end

  // A stalled address must stay presented unchanged until the consumer takes it.
  valid_holds_a: assert property (@(posedge clk) disable iff (reset || flush)
    (addr_valid && !addr_ready) |=> (addr_valid && $stable(addr_out)));

  // done is a single-cycle pulse.
  done_pulse_a: assert property (@(posedge clk) disable iff (reset || flush)
    done |=> !done);

endmodule
